ram_responder: RTL and testbench

- RAM-side responder for the unicore memory-controller interface; it answers MEM_RD/MEM_WB requests issued by the memory controller.
- It decodes the controller's ren/wen/addr/store and returns ramstate_t (FREE/BUSY/ACCESS/ERROR) after a fixed latency.
- It is backed by a word-addressed storage array.
- It serves as the memory endpoint in system-level sims and is the golden responder for controller verification.

---
 rtl/ram_responder_pkg.sv | 47 ++++
 rtl/ram_responder_array.sv | 37 +++
 rtl/ram_responder.sv | 82 ++++++++
 tb/tb_ram_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared memory-interface types for the RAM responder and the memory controller.
// Holds the response encoding, the responder FSM states and the latched-request layout.
package ram_responder_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WB   = 2'd2
  } mem_req_t;

  localparam int unsigned RAM_DEFAULT_LAT       = 2;
  localparam int unsigned RAM_DEFAULT_DEPTH_LOG = 10;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } ram_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } resp_state_t;

  function automatic ramstate_t state_to_ramstate(input resp_state_t s);
    ramstate_t r;
    r = FREE;
    unique case (s)
      IDLE:  r = FREE;
      WAIT:  r = BUSY;
      DONE:  r = ACCESS;
      FAULT: r = ERROR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_responder_array.sv
// Word-addressed storage: synchronous write, registered read, whole array cleared on reset.
// rdata only updates on a read strobe, so it holds the last value read.
module ram_responder_array
  import ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = RAM_DEFAULT_DEPTH_LOG
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 we,
  input  logic                 re,
  input  logic [DEPTH_LOG-1:0] idx,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int unsigned Words = 2 ** DEPTH_LOG;

  logic [31:0] mem [Words];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < Words; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[idx] <= wdata;
      end
      if (re) begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/ram_responder.sv
// RAM-side responder: answers read/write requests with BUSY for RAM_LAT cycles, then ACCESS.
// Bad requests (both strobes, misaligned, out of range) answer ERROR and never touch storage.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned RAM_LAT       = RAM_DEFAULT_LAT,
  parameter int unsigned RAM_DEPTH_LOG = RAM_DEFAULT_DEPTH_LOG
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  resp_state_t state;
  logic [3:0]  cnt;
  ram_req_t    latch;
  ram_req_t    live;
  resp_state_t eval_state;
  logic        present;
  logic        bad;
  logic        match;
  logic        finish;
  logic        mem_we;
  logic        mem_re;

  assign live = '{ren: ramREN, wen: ramWEN, addr: ramaddr, store: ramstore};

  always_comb begin
    present    = ramREN | ramWEN;
    bad        = (ramREN & ramWEN) |
                 (present & ((ramaddr[1:0] != 2'b00) ||
                             ((ramaddr[31:2] >> RAM_DEPTH_LOG) != '0)));
    eval_state = bad ? FAULT : (present ? WAIT : IDLE);
    // Store data only matters for a write; a read may leave it floating.
    match      = (live.ren == latch.ren) && (live.wen == latch.wen) &&
                 (live.addr == latch.addr) && (!latch.wen || live.store == latch.store);
    finish     = (state == WAIT) && match && (cnt == '0);
    mem_we     = finish & latch.wen;
    mem_re     = finish & latch.ren;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      latch <= '0;
    end else if (state == WAIT && match) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        state <= DONE;
      end
    end else begin
      // From IDLE/DONE/FAULT, or an aborted WAIT: treat inputs as a fresh request.
      state <= eval_state;
      if (eval_state == WAIT) begin
        latch <= live;
        cnt   <= 4'(RAM_LAT - 1);
      end
    end
  end

  assign ramstate = state_to_ramstate(state);

  ram_responder_array #(
    .DEPTH_LOG(RAM_DEPTH_LOG)
  ) u_array (
    .CLK  (CLK),
    .nRST (nRST),
    .we   (mem_we),
    .re   (mem_re),
    .idx  (latch.addr[RAM_DEPTH_LOG+1:2]),
    .wdata(latch.store),
    .rdata(ramload)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed and random accesses against a word-array reference,
// with two instances (latency 2 and latency 1) sharing the same request inputs.
module tb_ram_responder;
  import ram_responder_pkg::*;

  localparam int unsigned Lat      = 2;
  localparam int unsigned Lat1     = 1;
  localparam int unsigned DepthLog = 10;

  logic        CLK  = 1'b0;
  logic        nRST = 1'b1;
  logic        ramREN = 1'b0;
  logic        ramWEN = 1'b0;
  logic [31:0] ramaddr  = '0;
  logic [31:0] ramstore = '0;
  logic [31:0] ramload, ramload1;
  logic [1:0]  ramstate, ramstate1;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [2**DepthLog];
  logic [31:0] last_load;

  always #5 CLK = ~CLK;

  ram_responder #(.RAM_LAT(Lat), .RAM_DEPTH_LOG(DepthLog)) u_dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  ram_responder #(.RAM_LAT(Lat1), .RAM_DEPTH_LOG(DepthLog)) u_lat1 (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload1), .ramstate(ramstate1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s);
    ramREN = r; ramWEN = w; ramaddr = a; ramstore = s;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[DepthLog+1:2]);
  endfunction

  // Full, well-behaved access on the latency-2 instance, then drop and expect FREE.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] s,
                        input string tag);
    drive(!w, w, a, s);
    for (int i = 0; i < Lat; i++) begin
      tick();
      chk({tag, ".busy"}, 32'(ramstate), 32'(BUSY));
    end
    tick();
    chk({tag, ".access"}, 32'(ramstate), 32'(ACCESS));
    if (w) begin
      ref_mem[widx(a)] = s;
      chk({tag, ".load_kept"}, ramload, last_load);
    end else begin
      last_load = ref_mem[widx(a)];
      chk({tag, ".load"}, ramload, last_load);
    end
    drive(0, 0, '0, '0);
    tick();
    chk({tag, ".free"}, 32'(ramstate), 32'(FREE));
  endtask

  task automatic bad_req(input logic r, input logic w, input logic [31:0] a, input int hold,
                         input string tag);
    drive(r, w, a, 32'hFFFF_FFFF);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".error"}, 32'(ramstate), 32'(ERROR));
    end
    drive(0, 0, '0, '0);
    tick();
    chk({tag, ".free"}, 32'(ramstate), 32'(FREE));
  endtask

  // Expected response for cycle i (1-based) of a continuously held valid request.
  function automatic logic [1:0] held_state(input int i, input int lat);
    return (((i - 1) % (lat + 1)) < lat) ? BUSY : ACCESS;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    for (int i = 0; i < 2**DepthLog; i++) ref_mem[i] = '0;
    last_load = '0;

    // Asynchronous reset takes effect before any clock edge.
    #1 nRST = 1'b0;
    #2;
    chk("rst.state", 32'(ramstate), 32'(FREE));
    chk("rst.load", ramload, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    chk("rst.free", 32'(ramstate), 32'(FREE));

    access(0, 32'h40, '0, "rd40");
    access(1, 32'h100, 32'hDEAD_BEEF, "wr100");
    access(0, 32'h100, '0, "rd100");

    // Mid-access change restarts the full latency on the new address.
    access(1, 32'h10, 32'h1111_1111, "wr10");
    access(1, 32'h14, 32'h1414_1414, "wr14");
    drive(1, 0, 32'h10, '0);
    tick();
    chk("chg.busy0", 32'(ramstate), 32'(BUSY));
    drive(1, 0, 32'h14, '0);
    for (int i = 0; i < Lat; i++) begin
      tick();
      chk("chg.busy", 32'(ramstate), 32'(BUSY));
    end
    tick();
    chk("chg.access", 32'(ramstate), 32'(ACCESS));
    last_load = ref_mem[widx(32'h14)];
    chk("chg.load", ramload, last_load);
    drive(0, 0, '0, '0);
    tick();
    chk("chg.free", 32'(ramstate), 32'(FREE));

    bad_req(1, 1, 32'h100, 3, "both");
    bad_req(0, 1, 32'h102, 2, "misalign");
    bad_req(1, 0, 32'h1000, 2, "range");
    access(0, 32'h100, '0, "rd100_after_err");

    // Held read: repeated completions with no dedup, on both latencies.
    d = $urandom;
    access(1, 32'h20, d, "wr20");
    drive(1, 0, 32'h20, '0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("held.l2", 32'(ramstate), 32'(held_state(i, Lat)));
      chk("held.l1", 32'(ramstate1), 32'(held_state(i, Lat1)));
      if (held_state(i, Lat1) == ACCESS) chk("held.l1load", ramload1, ref_mem[widx(32'h20)]);
    end
    last_load = ref_mem[widx(32'h20)];
    chk("held.l2load", ramload, last_load);
    drive(0, 0, '0, '0);
    tick();
    chk("held.free2", 32'(ramstate), 32'(FREE));
    chk("held.free1", 32'(ramstate1), 32'(FREE));

    // Random traffic over a small window so reads hit earlier writes.
    for (int n = 0; n < 30; n++) begin
      a = 32'h200 + {26'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      if ($urandom_range(0, 9) == 0) bad_req(1, 0, a | 32'h1, 1, "rnd.bad");
      else access($urandom_range(0, 1) == 1, a, d, "rnd");
    end

    // Reset during BUSY of a write: aborted, and storage cleared.
    drive(0, 1, 32'h24, 32'hCAFE_F00D);
    tick();
    chk("rstmid.busy", 32'(ramstate), 32'(BUSY));
    #2 nRST = 1'b0;
    #1;
    chk("rstmid.state", 32'(ramstate), 32'(FREE));
    chk("rstmid.load", ramload, 32'h0);
    for (int i = 0; i < 2**DepthLog; i++) ref_mem[i] = '0;
    last_load = '0;
    drive(0, 0, '0, '0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    chk("rstmid.free", 32'(ramstate), 32'(FREE));
    access(0, 32'h24, '0, "rd24");
    access(0, 32'h100, '0, "rd100_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
